// File: rtl/guard_pkg.sv
// Shared types and helpers for the guard reset controller: FSM state encoding
// and fault-cause bit layout.
package guard_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISOLATE = 2'd1,
    ST_RESET   = 2'd2,
    ST_HOLD    = 2'd3
  } guard_rst_state_e;

  localparam int unsigned CauseRd = 0;
  localparam int unsigned CauseWr = 1;

  function automatic logic [1:0] cause_bits(input logic rd_req, input logic rd_irq,
                                            input logic wr_req, input logic wr_irq);
    logic [1:0] c;
    c          = 2'b00;
    c[CauseRd] = rd_req | rd_irq;
    c[CauseWr] = wr_req | wr_irq;
    return c;
  endfunction

endpackage

// File: rtl/guard_reset_ctrl_chk.sv
// Simulation-only invariants for guard_reset_ctrl: the subordinate reset may
// only be driven while isolated and while the controller sits in RESET.
module guard_reset_ctrl_chk
  import guard_pkg::*;
(
  input logic       clk_i,
  input logic       rst_i,
  input logic       isolate,
  input logic       slv_rst,
  input logic [1:0] state
);

  a_rst_implies_iso : assert property (@(posedge clk_i) disable iff (rst_i)
    slv_rst |-> isolate);

  a_rst_only_in_reset : assert property (@(posedge clk_i) disable iff (rst_i)
    slv_rst |-> (state == ST_RESET));

endmodule

// File: rtl/guard_reset_ctrl.sv
// Latches read/write guard faults, isolates the subordinate, drains with a
// bounded wait, pulses the subordinate reset and holds until software clears.
module guard_reset_ctrl
  import guard_pkg::*;
#(
  parameter int unsigned RstCycles    = 16,
  parameter int unsigned DrainTimeout = 256
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rd_reset_req_i,
  input  logic       wr_reset_req_i,
  input  logic       rd_irq_i,
  input  logic       wr_irq_i,
  input  logic       outstanding_i,
  input  logic       reset_clear_i,
  output logic       isolate_o,
  output logic       slv_rst_o,
  output logic       irq_o,
  output logic [1:0] cause_o,
  output logic       drain_forced_o,
  output logic [1:0] state_o
);

  localparam int unsigned DrainW = $clog2(DrainTimeout + 1);
  localparam int unsigned RstW   = $clog2(RstCycles + 1);
  localparam logic [DrainW-1:0] DrainLast = DrainW'(DrainTimeout - 1);
  localparam logic [DrainW-1:0] DrainMax  = DrainW'(DrainTimeout);
  localparam logic [RstW-1:0]   RstLast   = RstW'(RstCycles - 1);

  guard_rst_state_e  state_r;
  logic [DrainW-1:0] drain_cnt_r;
  logic [RstW-1:0]   rst_cnt_r;
  logic              isolate_r;
  logic              slv_rst_r;
  logic              irq_r;
  logic [1:0]        cause_r;
  logic              drain_forced_r;
  logic              fault_s;
  logic [1:0]        new_cause_s;

  // Fault detection and per-side cause decode
  always_comb begin
    new_cause_s = cause_bits(rd_reset_req_i, rd_irq_i, wr_reset_req_i, wr_irq_i);
    fault_s     = |new_cause_s;
  end

  // Controller FSM with drain and reset-pulse counters; all outputs registered
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r        <= ST_IDLE;
      drain_cnt_r    <= '0;
      rst_cnt_r      <= '0;
      isolate_r      <= 1'b0;
      slv_rst_r      <= 1'b0;
      irq_r          <= 1'b0;
      cause_r        <= 2'b00;
      drain_forced_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (fault_s) begin
            state_r     <= ST_ISOLATE;
            isolate_r   <= 1'b1;
            irq_r       <= 1'b1;
            cause_r     <= cause_r | new_cause_s;
            drain_cnt_r <= '0;
          end
        end
        ST_ISOLATE: begin
          cause_r <= cause_r | new_cause_s;
          if (drain_cnt_r != DrainMax) begin
            drain_cnt_r <= drain_cnt_r + DrainW'(1);
          end
          // A clean drain takes priority: forced is only flagged if still busy
          if (!outstanding_i || (drain_cnt_r == DrainLast)) begin
            state_r        <= ST_RESET;
            slv_rst_r      <= 1'b1;
            rst_cnt_r      <= '0;
            drain_forced_r <= drain_forced_r | outstanding_i;
          end
        end
        ST_RESET: begin
          cause_r <= cause_r | new_cause_s;
          if (rst_cnt_r == RstLast) begin
            state_r   <= ST_HOLD;
            slv_rst_r <= 1'b0;
          end else begin
            rst_cnt_r <= rst_cnt_r + RstW'(1);
          end
        end
        ST_HOLD: begin
          if (reset_clear_i) begin
            state_r        <= ST_IDLE;
            isolate_r      <= 1'b0;
            irq_r          <= 1'b0;
            cause_r        <= 2'b00;
            drain_forced_r <= 1'b0;
            drain_cnt_r    <= '0;
            rst_cnt_r      <= '0;
          end else begin
            cause_r <= cause_r | new_cause_s;
          end
        end
        default: begin
          state_r        <= ST_IDLE;
          drain_cnt_r    <= '0;
          rst_cnt_r      <= '0;
          isolate_r      <= 1'b0;
          slv_rst_r      <= 1'b0;
          irq_r          <= 1'b0;
          cause_r        <= 2'b00;
          drain_forced_r <= 1'b0;
        end
      endcase
    end
  end

  assign isolate_o      = isolate_r;
  assign slv_rst_o      = slv_rst_r;
  assign irq_o          = irq_r;
  assign cause_o        = cause_r;
  assign drain_forced_o = drain_forced_r;
  assign state_o        = state_r;

  guard_reset_ctrl_chk u_chk (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .isolate (isolate_r),
    .slv_rst (slv_rst_r),
    .state   (state_r)
  );

endmodule

// File: tb/tb_guard_reset_ctrl.sv
// Directed bench for guard_reset_ctrl (RstCycles=16, DrainTimeout=8): a vector
// table plus hand-written sequences for drain, reset pulse and clear handling.
module tb_guard_reset_ctrl;
  import guard_pkg::*;

  logic       clk_i = 1'b0;
  logic       rst_i, rd_reset_req_i, wr_reset_req_i, rd_irq_i, wr_irq_i;
  logic       outstanding_i, reset_clear_i;
  logic       isolate_o, slv_rst_o, irq_o, drain_forced_o;
  logic [1:0] cause_o, state_o;

  guard_reset_ctrl #(.RstCycles(16), .DrainTimeout(8)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .rd_reset_req_i (rd_reset_req_i),
    .wr_reset_req_i (wr_reset_req_i),
    .rd_irq_i       (rd_irq_i),
    .wr_irq_i       (wr_irq_i),
    .outstanding_i  (outstanding_i),
    .reset_clear_i  (reset_clear_i),
    .isolate_o      (isolate_o),
    .slv_rst_o      (slv_rst_o),
    .irq_o          (irq_o),
    .cause_o        (cause_o),
    .drain_forced_o (drain_forced_o),
    .state_o        (state_o)
  );

  always #5 clk_i = ~clk_i;

  // input vector layout {rst, rd_req, wr_req, rd_irq, wr_irq, outstanding, clear}
  localparam logic [6:0] I_NONE = 7'b0000000;
  localparam logic [6:0] I_RST  = 7'b1000000;
  localparam logic [6:0] I_RD   = 7'b0100000;
  localparam logic [6:0] I_WR   = 7'b0010000;
  localparam logic [6:0] I_RDI  = 7'b0001000;
  localparam logic [6:0] I_WRI  = 7'b0000100;
  localparam logic [6:0] I_OUT  = 7'b0000010;
  localparam logic [6:0] I_CLR  = 7'b0000001;
  localparam logic [7:0] E_ZERO = 8'h00;

  typedef struct {
    logic [6:0] in;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[12];
  int   n_pass  = 0;
  int   n_total = 0;

  // expected output vector {isolate, slv_rst, irq, cause[1:0], forced, state[1:0]}
  function automatic logic [7:0] ex(input logic iso, input logic srst, input logic irq,
                                    input logic [1:0] cause, input logic forced,
                                    input logic [1:0] st);
    return {iso, srst, irq, cause, forced, st};
  endfunction

  function automatic vec_t mk(input logic [6:0] in, input logic [7:0] exp);
    vec_t v;
    v.in  = in;
    v.exp = exp;
    return v;
  endfunction

  task automatic set_in(input logic [6:0] v);
    {rst_i, rd_reset_req_i, wr_reset_req_i, rd_irq_i, wr_irq_i, outstanding_i, reset_clear_i} = v;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] exp);
    logic [7:0] act;
    act = {isolate_o, slv_rst_o, irq_o, cause_o, drain_forced_o, state_o};
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b (iso,srst,irq,cause,forced,state)", name, act, exp);
  endtask

  task automatic step(input logic [6:0] v, input string name, input logic [7:0] exp);
    set_in(v);
    tick();
    chk(name, exp);
  endtask

  // n further cycles inside RESET, then the edge that lands in HOLD
  task automatic run_reset(input int n, input logic [1:0] cause, input logic forced);
    for (int i = 0; i < n; i++) step(I_NONE, "reset_pulse", ex(1'b1, 1'b1, 1'b1, cause, forced, 2'd2));
    step(I_NONE, "enter_hold", ex(1'b1, 1'b0, 1'b1, cause, forced, 2'd3));
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) step(vecs[i].in, $sformatf("vec%0d", i), vecs[i].exp);
  endtask

  initial begin
    vecs[0]  = mk(I_RD | I_WR,   ex(1'b1, 1'b0, 1'b1, 2'b11, 1'b0, 2'd1));
    vecs[1]  = mk(I_NONE,        ex(1'b1, 1'b1, 1'b1, 2'b11, 1'b0, 2'd2));
    vecs[2]  = mk(I_CLR | I_WRI, E_ZERO);
    vecs[3]  = mk(I_WRI,         ex(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 2'd1));
    vecs[4]  = mk(I_OUT,         ex(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 2'd1));
    vecs[5]  = mk(I_NONE,        ex(1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 2'd2));
    vecs[6]  = mk(I_CLR,         E_ZERO);
    vecs[7]  = mk(I_CLR,         E_ZERO);
    vecs[8]  = mk(I_NONE,        E_ZERO);
    vecs[9]  = mk(I_RDI,         ex(1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 2'd1));
    vecs[10] = mk(I_RST,         E_ZERO);
    vecs[11] = mk(I_NONE,        E_ZERO);

    set_in(I_RST);
    tick();
    step(I_RST, "reset_state", E_ZERO);

    // 1: rd request with nothing outstanding
    step(I_RD, "t1_isolate", ex(1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 2'd1));
    step(I_NONE, "t1_reset_entry", ex(1'b1, 1'b1, 1'b1, 2'b01, 1'b0, 2'd2));
    run_reset(15, 2'b01, 1'b0);
    step(I_CLR, "t1_clear", E_ZERO);

    // 2: wr request, outstanding for the first 5 ISOLATE cycles
    step(I_WR | I_OUT, "t2_isolate", ex(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 2'd1));
    for (int i = 0; i < 5; i++) step(I_OUT, "t2_drain_wait", ex(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 2'd1));
    step(I_NONE, "t2_reset_entry", ex(1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 2'd2));
    run_reset(15, 2'b10, 1'b0);
    step(I_CLR, "t2_clear", E_ZERO);

    // 3: outstanding stuck high -> drain timeout after 8 cycles
    step(I_RDI | I_OUT, "t3_isolate", ex(1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 2'd1));
    for (int i = 1; i < 8; i++) step(I_OUT, "t3_drain_wait", ex(1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 2'd1));
    step(I_OUT, "t3_forced_exit", ex(1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 2'd2));
    run_reset(15, 2'b01, 1'b1);
    step(I_CLR, "t3_clear", E_ZERO);

    // 4: cause accumulation during RESET
    step(I_RDI, "t4_isolate", ex(1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 2'd1));
    step(I_NONE, "t4_reset_entry", ex(1'b1, 1'b1, 1'b1, 2'b01, 1'b0, 2'd2));
    step(I_WR, "t4_wr_in_reset", ex(1'b1, 1'b1, 1'b1, 2'b11, 1'b0, 2'd2));
    run_reset(14, 2'b11, 1'b0);
    step(I_CLR, "t4_clear", E_ZERO);

    // 5: clears outside HOLD are ignored
    step(I_RD | I_OUT, "t5_isolate", ex(1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 2'd1));
    step(I_OUT | I_CLR, "t5_clr_isolate", ex(1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 2'd1));
    step(I_NONE, "t5_reset_entry", ex(1'b1, 1'b1, 1'b1, 2'b01, 1'b0, 2'd2));
    step(I_CLR, "t5_clr_reset", ex(1'b1, 1'b1, 1'b1, 2'b01, 1'b0, 2'd2));
    run_reset(14, 2'b01, 1'b0);
    step(I_NONE, "t5_hold_stays", ex(1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 2'd3));
    step(I_CLR, "t5_clear", E_ZERO);

    // 6: synchronous reset in the middle of RESET, then a fresh sequence
    step(I_RD, "t6_isolate", ex(1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 2'd1));
    step(I_NONE, "t6_reset_entry", ex(1'b1, 1'b1, 1'b1, 2'b01, 1'b0, 2'd2));
    for (int i = 0; i < 3; i++) step(I_NONE, "t6_in_reset", ex(1'b1, 1'b1, 1'b1, 2'b01, 1'b0, 2'd2));
    step(I_RST, "t6_rst_mid", E_ZERO);
    step(I_NONE, "t6_idle", E_ZERO);
    step(I_WRI, "t6_isolate2", ex(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 2'd1));
    step(I_NONE, "t6_reset_entry2", ex(1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 2'd2));
    run_reset(15, 2'b10, 1'b0);
    step(I_CLR, "t6_clear", E_ZERO);

    // table: simultaneous faults, clear-vs-fault in HOLD, idle clears, reset
    run_vecs(0, 1);
    run_reset(15, 2'b11, 1'b0);
    run_vecs(2, 5);
    run_reset(15, 2'b10, 1'b0);
    run_vecs(6, 11);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/guard_reset_ctrl.md
Name: guard_reset_ctrl

Overview:
- Downstream consumer of the read guard's and write guard's `reset_req_o` / `irq_o` outputs.
- Latches any guard fault and isolates the subordinate by gating new AR/AW.
- Drains outstanding transactions, with a bounded wait, then applies a fixed-length subordinate reset.
- Holds isolation and the interrupt until software clears it. All outputs are registered.

Parameters:
- RstCycles, 16, subordinate reset pulse length in cycles; must be >= 1.
- DrainTimeout, 256, maximum cycles spent waiting for outstanding transactions to drain; must be >= 1.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- rd_reset_req_i  in  1  reset request from the read guard; may be a single-cycle pulse
- wr_reset_req_i  in  1  reset request from the write guard; may be a single-cycle pulse
- rd_irq_i  in  1  read guard interrupt; logged as cause only
- wr_irq_i  in  1  write guard interrupt; logged as cause only
- outstanding_i  in  1  high while the subordinate has any outstanding AR/AW transaction
- reset_clear_i  in  1  software clear (register write pulse)
- isolate_o  out  1  when high, upstream gating forces ar_valid/aw_valid low toward the subordinate
- slv_rst_o  out  1  subordinate reset, active-high
- irq_o  out  1  level interrupt
- cause_o  out  2  sticky fault cause {wr, rd}
- drain_forced_o  out  1  sticky; the drain wait ended by timeout
- state_o  out  2  FSM state for status register: IDLE=0, ISOLATE=1, RESET=2, HOLD=3

Behaviour:
- Reset (rst_i sampled high at a clock edge): state IDLE. All outputs and counters are 0.
- Reset applied mid-operation aborts any state. slv_rst_o drops the next cycle.
- Fault definition: fault = rd_reset_req_i | wr_reset_req_i | rd_irq_i | wr_irq_i.
- IDLE, fault seen at edge n:
  - state is ISOLATE at n+1.
  - isolate_o=1 and irq_o=1 from n+1.
  - cause_o |= {wr_reset_req_i|wr_irq_i, rd_reset_req_i|rd_irq_i}.
  - drain counter cleared.
- Cause accumulation: cause_o keeps OR-ing new faults in every non-IDLE state. Simultaneous rd and wr faults give cause_o=2'b11.
- ISOLATE:
  - Drain counter increments each cycle.
  - Exit to RESET at the next edge when outstanding_i==0, or when the counter reaches DrainTimeout-1.
  - The timeout exit sets drain_forced_o=1. If both conditions are true together, the exit counts as a clean drain.
  - If outstanding_i==0 on entry, ISOLATE lasts exactly 1 cycle.
- RESET:
  - slv_rst_o=1 for exactly RstCycles cycles. Counter width is $clog2(RstCycles+1).
  - Then go to HOLD; slv_rst_o=0 in HOLD.
- HOLD:
  - isolate_o=1 and irq_o=1 remain.
  - reset_clear_i=1 → IDLE next cycle, clearing irq_o, cause_o, drain_forced_o and isolate_o.
- reset_clear_i outside HOLD is ignored and not remembered.
- Fault and clear in the same HOLD cycle: clear wins → IDLE. A fault still asserted in the following cycle re-triggers ISOLATE.
- Drain counter width is $clog2(DrainTimeout+1). It saturates and never wraps.
- Simulation assertions:
  - slv_rst_o implies isolate_o.
  - slv_rst_o is never high outside RESET.

Decomposition:
- Package guard_pkg holds:
  - the state enum typedef guard_rst_state_e (2 bits);
  - the cause bit index localparams CauseRd=0, CauseWr=1.
- No sub-module is required. The single FSM plus two counters fit in one module.

Test Plan:
1. Reset, then 1-cycle rd_reset_req_i with outstanding_i=0 at edge 10 → isolate_o high at 11; slv_rst_o high cycles 12..27 (16 cycles); state_o=3 at 28; cause_o=2'b01; drain_forced_o=0.
2. wr_reset_req_i pulse with outstanding_i held high for 5 cycles → ISOLATE lasts 6 cycles; RESET then follows; cause_o=2'b10; drain_forced_o=0.
3. outstanding_i stuck high with DrainTimeout=8 → ISOLATE lasts exactly 8 cycles; drain_forced_o=1; slv_rst_o pulse follows.
4. rd_irq_i at edge 10 and wr_reset_req_i during RESET → cause_o=2'b11 in HOLD; reset_clear_i in HOLD → all outputs 0 next cycle; state_o=0.
5. reset_clear_i pulsed during ISOLATE and RESET → ignored; irq_o stays 1 until a clear in HOLD.
6. rst_i asserted in the middle of RESET → slv_rst_o, isolate_o and irq_o are 0 the next cycle; a new fault afterwards restarts the full sequence.
